// File: rtl/kggramastogramas.sv
// Packed-BCD kg/g display value to binary grams, one digit per clock (Horner).
// Result is range-checked against LIMITE; done pulses once per finished conversion.
module kggramastogramas #(
   parameter int LIMITE = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] pesokg,
   output logic [11:0] gramas,
   output logic        busy,
   output logic        done,
   output logic        erro
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   localparam logic [13:0] LIM = 14'(LIMITE);

   state_t      state, state_nx;
   logic [15:0] pk;
   logic [13:0] acc;
   logic [13:0] acc_nx;
   logic [1:0]  idx;
   logic        bad_digit;
   logic [3:0]  digit;
   logic        invalid;
   logic        bad_in;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (idx == 2'd0) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      digit = pk[3:0];
      case (idx)
         2'd3:    digit = pk[15:12];
         2'd2:    digit = pk[11:8];
         2'd1:    digit = pk[7:4];
         default: digit = pk[3:0];
      endcase
   end

   // acc*10 as (acc<<3)+(acc<<1); 9999 fits in 14 bits.
   assign acc_nx  = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + {10'd0, digit};
   assign invalid = bad_digit | (acc > LIM);
   assign bad_in  = (pesokg[15:12] > 4'd9) | (pesokg[11:8] > 4'd9) |
                    (pesokg[7:4]   > 4'd9) | (pesokg[3:0]  > 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pk        <= '0;
         acc       <= '0;
         idx       <= '0;
         bad_digit <= 1'b0;
         gramas    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         erro      <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  pk        <= pesokg;
                  acc       <= '0;
                  idx       <= 2'd3;
                  bad_digit <= bad_in;
               end
            end
            CALC: begin
               acc <= acc_nx;
               idx <= idx - 2'd1;
            end
            FIN: begin
               erro <= invalid;
               done <= 1'b1;
               if (!invalid) gramas <= acc[11:0];
            end
            default: ;
         endcase
      end
   end

endmodule
